// File: rtl/debug_pkg.sv
// Shared constants for the debug read-out path: state encoding, default
// bank geometry and word/byte sizing used by the dump unit and the UART debug unit.
package debug_pkg;

  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_SEND  = ST_SEND,
    S_DONE  = ST_DONE
  } dump_state_t;

  // Byte count for an arbitrary word width, used when a module is parameterised
  // away from the default register width.
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Latches one register word and presents it MSB byte first on a registered
// valid/data pair, shifting on every accepted byte.
module word_serializer
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  last_byte
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] r_shiftReg;
  logic [CW-1:0]         r_byteCount;
  logic                  r_valid;
  logic                  w_accept;
  logic                  w_lastCount;

  assign w_accept    = r_valid & tx_ready;
  assign w_lastCount = (r_byteCount == CW'(BYTES - 1));
  assign last_byte   = w_accept & w_lastCount;

  assign tx_data  = r_shiftReg[DATA_WIDTH-1 -: 8];
  assign tx_valid = r_valid;

  // Valid drops on the final accepted byte so the owner sees one idle cycle
  // between words while the next register is fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shiftReg  <= '0;
      r_byteCount <= '0;
      r_valid     <= 1'b0;
    end else if (load) begin
      r_shiftReg  <= data_in;
      r_byteCount <= '0;
      r_valid     <= 1'b1;
    end else if (w_accept) begin
      r_shiftReg  <= r_shiftReg << 8;
      r_byteCount <= r_byteCount + 1'b1;
      if (w_lastCount) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// Walks the register bank through its debug read port on request and streams
// every word, MSB byte first, toward the UART transmitter.
module reg_dump_unit
  import debug_pkg::*;
#(
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                        ClockIn,
  input  logic                        Reset,
  input  logic                        Start,
  output logic [$clog2(NUM_REGS)-1:0] DebugAddr,
  input  logic [DATA_WIDTH-1:0]       DebugData,
  output logic [7:0]                  TxData,
  output logic                        TxValid,
  input  logic                        TxReady,
  output logic                        Busy,
  output logic                        Done
);

  localparam int IW = $clog2(NUM_REGS);

  dump_state_t   r_state;
  dump_state_t   w_nextState;
  logic [IW-1:0] r_index;
  logic          w_load;
  logic          w_lastByte;
  logic          w_lastReg;

  assign w_lastReg = (r_index == IW'(NUM_REGS - 1));
  assign DebugAddr = r_index;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (ClockIn),
    .rst      (Reset),
    .load     (w_load),
    .data_in  (DebugData),
    .tx_ready (TxReady),
    .tx_data  (TxData),
    .tx_valid (TxValid),
    .last_byte(w_lastByte)
  );

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start is only honoured from IDLE; requests during a dump are dropped.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_nextState = S_FETCH;
        end
      end
      S_FETCH: begin
        w_load      = 1'b1;
        w_nextState = S_SEND;
      end
      S_SEND: begin
        if (w_lastByte) begin
          w_nextState = w_lastReg ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_index <= '0;
          end
        end
        S_SEND: begin
          if (w_lastByte && !w_lastReg) begin
            r_index <= r_index + 1'b1;
          end
        end
        S_DONE: begin
          r_index <= '0;
        end
        default: begin
          r_index <= r_index;
        end
      endcase
    end
  end

endmodule
